// File: rtl/des_round_key_sequencer.sv
// Streaming DES key schedule: takes one post-PC-1 key and emits the 16 round keys one per
// handshake, K1..K16 (left rotates) for encrypt or K16..K1 (right rotates) for decrypt.

module des_key_permutation2 (
    input  logic [0:55] cd,
    output logic [0:47] rk
);

    assign rk = {cd[13], cd[16], cd[10], cd[23], cd[0],  cd[4],
                 cd[2],  cd[27], cd[14], cd[5],  cd[20], cd[9],
                 cd[22], cd[18], cd[11], cd[3],  cd[25], cd[7],
                 cd[15], cd[6],  cd[26], cd[19], cd[12], cd[1],
                 cd[40], cd[51], cd[30], cd[36], cd[46], cd[54],
                 cd[29], cd[39], cd[50], cd[44], cd[32], cd[47],
                 cd[43], cd[48], cd[38], cd[55], cd[33], cd[52],
                 cd[45], cd[41], cd[49], cd[35], cd[28], cd[31]};

endmodule

module des_round_key_sequencer (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [0:55] input_key,
    input  logic        is_encrypt,
    input  logic        abort,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [0:47] rk_data,
    output logic [3:0]  rk_round,
    output logic        rk_last,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state, state_next;
    logic [0:55] cd, cd_next;
    logic [3:0]  round, round_next;
    logic        mode, mode_next;
    logic        handshake;
    logic        accept;
    logic [0:55] load_cd;

    // Encrypt and decrypt tables differ only at index 0 (decrypt starts from C16/D16 == C0/D0).
    function automatic logic [1:0] shift_amt(input logic [3:0] idx, input logic enc);
        logic [1:0] amt;
        case (idx)
            4'd0:                amt = enc ? 2'd1 : 2'd0;
            4'd1, 4'd8, 4'd15:   amt = 2'd1;
            default:             amt = 2'd2;
        endcase
        return amt;
    endfunction

    function automatic logic [0:55] rotate_cd(input logic [0:55] v, input logic left,
                                              input logic [1:0] amt);
        logic [0:27] c;
        logic [0:27] d;
        c = v[0:27];
        d = v[28:55];
        case ({left, amt})
            3'b1_01: begin c = {c[1:27], c[0]};      d = {d[1:27], d[0]};      end
            3'b1_10: begin c = {c[2:27], c[0:1]};    d = {d[2:27], d[0:1]};    end
            3'b0_01: begin c = {c[27], c[0:26]};     d = {d[27], d[0:26]};     end
            3'b0_10: begin c = {c[26:27], c[0:25]};  d = {d[26:27], d[0:25]};  end
            default: ;
        endcase
        return {c, d};
    endfunction

    des_key_permutation2 u_pc2 (
        .cd (cd),
        .rk (rk_data)
    );

    assign busy      = (state == RUN);
    assign rk_valid  = busy;
    assign rk_round  = round;
    assign rk_last   = busy && (round == 4'd15);
    assign handshake = rk_valid && rk_ready;
    // A key may reload on the final handshake, but abort always suppresses that reload.
    assign key_ready = (state == IDLE) || (handshake && rk_last && !abort);
    assign accept    = key_valid && key_ready;
    assign load_cd   = rotate_cd(input_key, is_encrypt, shift_amt(4'd0, is_encrypt));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cd    <= '0;
            round <= 4'd0;
            mode  <= 1'b1;
        end else begin
            state <= state_next;
            cd    <= cd_next;
            round <= round_next;
            mode  <= mode_next;
        end
    end

    always_comb begin
        state_next = state;
        cd_next    = cd;
        round_next = round;
        mode_next  = mode;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                    cd_next    = load_cd;
                    mode_next  = is_encrypt;
                    round_next = 4'd0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    round_next = 4'd0;
                end else if (handshake) begin
                    if (round != 4'd15) begin
                        round_next = round + 4'd1;
                        cd_next    = rotate_cd(cd, mode, shift_amt(round + 4'd1, mode));
                    end else if (accept) begin
                        cd_next    = load_cd;
                        mode_next  = is_encrypt;
                        round_next = 4'd0;
                    end else begin
                        state_next = IDLE;
                        round_next = 4'd0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
